instruction_decoder: RTL and testbench



---
 rtl/instruction_decoder_pkg.sv | 38 +++
 rtl/sign_extend.sv | 18 +
 rtl/instruction_decoder.sv | 79 +++++++
 tb/tb_instruction_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_decoder_pkg.sv
// rtl/instruction_decoder_pkg.sv - shared constants for the Simple RISC Machine instruction decoder
package instruction_decoder_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] CMP = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] MVN = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam int INSTR_W     = 16;
  localparam int OPCODE_MSB  = 15;
  localparam int OPCODE_LSB  = 13;
  localparam int OP_MSB      = 12;
  localparam int OP_LSB      = 11;
  localparam int RN_MSB      = 10;
  localparam int RN_LSB      = 8;
  localparam int RD_MSB      = 7;
  localparam int RD_LSB      = 5;
  localparam int SHIFT_MSB   = 4;
  localparam int SHIFT_LSB   = 3;
  localparam int RM_MSB      = 2;
  localparam int RM_LSB      = 0;
  localparam int IMM5_W      = 5;
  localparam int IMM8_W      = 8;

  // True for the encodings the machine actually executes.
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    is_legal = ((opc == OPC_MOV) && ((op == 2'b10) || (op == 2'b00))) ||
               (opc == OPC_ALU);
  endfunction

endpackage

// File: rtl/sign_extend.sv
// rtl/sign_extend.sv - replicates the MSB of an IN_W-bit field up to OUT_W bits
module sign_extend #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  generate
    if (OUT_W > IN_W) begin : g_ext
      assign out = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
    end else begin : g_pass
      assign out = in[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - instruction register and field decoder; INSTR_DECODE_ILLEGAL_EN adds the illegal output
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [15:0]       in,
  input  logic [2:0]        nsel,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [1:0]        shift,
  output logic [2:0]        readnum,
`ifdef INSTR_DECODE_ILLEGAL_EN
  output logic [2:0]        writenum,
  output logic              illegal
`else
  output logic [2:0]        writenum
`endif
);

  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] instr_d;
  logic [2:0]         regnum;

  always_comb begin
    instr_d = instr_q;
    if (load) begin
      instr_d = in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
    end else begin
      instr_q <= instr_d;
    end
  end

  assign opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign op     = instr_q[OP_MSB:OP_LSB];
  assign ALUop  = instr_q[OP_MSB:OP_LSB];
  assign shift  = instr_q[SHIFT_MSB:SHIFT_LSB];

  sign_extend #(.IN_W(IMM5_W), .OUT_W(DATA_W)) u_sx5 (
    .in  (instr_q[IMM5_W-1:0]),
    .out (sximm5)
  );

  sign_extend #(.IN_W(IMM8_W), .OUT_W(DATA_W)) u_sx8 (
    .in  (instr_q[IMM8_W-1:0]),
    .out (sximm8)
  );

  // Non-one-hot selects fall back to R0 rather than OR-ing fields together.
  always_comb begin
    regnum = 3'b000;
    case (nsel)
      NSEL_RN: regnum = instr_q[RN_MSB:RN_LSB];
      NSEL_RD: regnum = instr_q[RD_MSB:RD_LSB];
      NSEL_RM: regnum = instr_q[RM_MSB:RM_LSB];
      default: regnum = 3'b000;
    endcase
  end

  assign readnum  = regnum;
  assign writenum = regnum;

`ifdef INSTR_DECODE_ILLEGAL_EN
  assign illegal = ~is_legal(opcode, op);
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - directed self-checking bench for instruction_decoder
module tb_instruction_decoder;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [15:0]       in;
  logic [2:0]        nsel;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  logic [1:0]        shift;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
`ifdef INSTR_DECODE_ILLEGAL_EN
  logic              illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_decoder #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .in       (in),
    .nsel     (nsel),
    .opcode   (opcode),
    .op       (op),
    .ALUop    (ALUop),
    .sximm5   (sximm5),
    .sximm8   (sximm8),
    .shift    (shift),
    .readnum  (readnum),
`ifdef INSTR_DECODE_ILLEGAL_EN
    .writenum (writenum),
    .illegal  (illegal)
`else
    .writenum (writenum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load = 1'b1;
    in   = w;
    edge_step();
    load = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [2:0] rn, input logic [2:0] rd, input logic [2:0] rm);
    nsel = 3'b100; #1;
    check({tag, " rn"}, 32'(readnum), 32'(rn));
    check({tag, " rn_wr"}, 32'(writenum), 32'(rn));
    nsel = 3'b010; #1;
    check({tag, " rd"}, 32'(readnum), 32'(rd));
    nsel = 3'b001; #1;
    check({tag, " rm"}, 32'(readnum), 32'(rm));
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    in    = 16'hFFFF;
    nsel  = 3'b100;
    #1;
    check("rst_async opcode", 32'(opcode), 32'h0);
    edge_step();
    check("rst opcode", 32'(opcode), 32'h0);
    check("rst op", 32'(op), 32'h0);
    check("rst aluop", 32'(ALUop), 32'h0);
    check("rst shift", 32'(shift), 32'h0);
    check("rst sximm5", 32'(sximm5), 32'h0);
    check("rst sximm8", 32'(sximm8), 32'h0);
    check_regs("rst", 3'd0, 3'd0, 3'd0);
`ifdef INSTR_DECODE_ILLEGAL_EN
    check("rst illegal", 32'(illegal), 32'h1);
`endif
    reset = 1'b0;
    load  = 1'b0;

    load_word(16'hD007);
    nsel = 3'b100; #1;
    check("mov opcode", 32'(opcode), 32'h6);
    check("mov op", 32'(op), 32'h2);
    check("mov aluop", 32'(ALUop), 32'h2);
    check("mov readnum", 32'(readnum), 32'h0);
    check("mov writenum", 32'(writenum), 32'h0);
    check("mov sximm8", 32'(sximm8), 32'h0007);
    check("mov sximm5", 32'(sximm5), 32'h0007);
    check("mov shift", 32'(shift), 32'h0);
`ifdef INSTR_DECODE_ILLEGAL_EN
    check("mov illegal", 32'(illegal), 32'h0);
`endif

    load_word(16'hA3B6);
    check_regs("add", 3'd3, 3'd5, 3'd6);
    check("add opcode", 32'(opcode), 32'h5);
    check("add aluop", 32'(ALUop), 32'h0);
    check("add shift", 32'(shift), 32'h2);
    nsel = 3'b011; #1;
    check("add nsel011", 32'(readnum), 32'h0);
    check("add nsel011 wr", 32'(writenum), 32'h0);
    nsel = 3'b000; #1;
    check("add nsel000", 32'(readnum), 32'h0);
    nsel = 3'b111; #1;
    check("add nsel111", 32'(readnum), 32'h0);
    nsel = 3'b110; #1;
    check("add nsel110", 32'(readnum), 32'h0);

    load_word(16'hD180);
    check("sx neg sximm8", 32'(sximm8), 32'hFF80);
    check("sx neg sximm5", 32'(sximm5), 32'h0000);
    load_word(16'hD110);
    check("sx neg5 sximm5", 32'(sximm5), 32'hFFF0);
    check("sx neg5 sximm8", 32'(sximm8), 32'h0010);

    load = 1'b0;
    in   = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("hold opcode", 32'(opcode), 32'h6);
      check("hold sximm5", 32'(sximm5), 32'hFFF0);
      check("hold sximm8", 32'(sximm8), 32'h0010);
    end

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst opcode", 32'(opcode), 32'h0);
    check("midrst op", 32'(op), 32'h0);
    check("midrst sximm5", 32'(sximm5), 32'h0);
    check("midrst sximm8", 32'(sximm8), 32'h0);
    nsel = 3'b100; #1;
    check("midrst readnum", 32'(readnum), 32'h0);
    reset = 1'b0;

    load = 1'b1;
    in   = 16'hA3B6;
    edge_step();
    check("b2b first shift", 32'(shift), 32'h2);
    in = 16'hD007;
    edge_step();
    load = 1'b0;
    check("b2b second opcode", 32'(opcode), 32'h6);
    check("b2b second sximm8", 32'(sximm8), 32'h0007);

`ifdef INSTR_DECODE_ILLEGAL_EN
    load_word(16'hA800);
    check("ill cmp", 32'(illegal), 32'h0);
    load_word(16'hC800);
    check("ill 110_01", 32'(illegal), 32'h1);
    load_word(16'hE000);
    check("ill 111_00", 32'(illegal), 32'h1);
    load_word(16'hC000);
    check("ill mov_reg", 32'(illegal), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
